// File: rtl/i2s_adc_sample_rx.sv
// rtl/i2s_adc_sample_rx.sv - I2S stereo sample receiver with valid/ready frame output.
// Optional slot-length checking is enabled by defining I2S_FRAME_CHECK_EN.
module i2s_adc_sample_rx #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              frame_err
);
  localparam int CW = $clog2(SLOT_W + 2);

  typedef enum logic [1:0] {SYNC, SHIFT, HOLD} state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lr_s1_q, lr_s2_q, sd_s1_q, sd_s2_q;

  state_t            state_q, state_d;
  logic              chan_q, chan_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic [DATA_W-1:0] right_hold_q, right_hold_d;
  logic              have_left_q, have_left_d;
  logic              pub_q, pub_d;
  logic              lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0] out_left_q, out_left_d, out_right_q, out_right_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic              bclk_rise, lr_edge, word_done;
`ifdef I2S_FRAME_CHECK_EN
  logic [CW-1:0]     slot_cnt_q, slot_cnt_d;
  logic              frame_err_q, frame_err_d;
`endif

  assign bclk_rise = bclk_s2_q & ~bclk_s3_q;
  assign lr_edge   = bclk_rise & (lr_s2_q != lr_prev_q);

  // The bclk rise that first sees a new lrclk level is the one-bit I2S delay slot,
  // so shifting starts on the following rise.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    have_left_d  = have_left_q;
    pub_d        = 1'b0;
    lr_prev_d    = lr_prev_q;
    out_left_d   = out_left_q;
    out_right_d  = out_right_q;
    out_valid_d  = out_valid_q & ~out_ready;
    overflow_d   = overflow_q;
    word_done    = 1'b0;
`ifdef I2S_FRAME_CHECK_EN
    slot_cnt_d   = slot_cnt_q;
    frame_err_d  = frame_err_q;
`endif
    if (bclk_rise) lr_prev_d = lr_s2_q;

    if (!enable) begin
      state_d     = SYNC;
      have_left_d = 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          if (lr_edge && !lr_s2_q) begin
            state_d     = SHIFT;
            chan_d      = 1'b0;
            bit_cnt_d   = '0;
            have_left_d = 1'b0;
`ifdef I2S_FRAME_CHECK_EN
            slot_cnt_d  = CW'(1);
`endif
          end
        end
        default: begin
          if (bclk_rise) begin
            if (state_q == SHIFT) begin
              shift_d = DATA_W'({shift_q, sd_s2_q});
              if (bit_cnt_q == CW'(DATA_W - 1)) begin
                word_done = 1'b1;
                state_d   = HOLD;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end
            if (lr_edge) begin
              state_d   = SHIFT;
              chan_d    = lr_s2_q;
              bit_cnt_d = '0;
            end
            if (word_done) begin
              if (!chan_q) begin
                left_hold_d = shift_d;
                have_left_d = 1'b1;
              end else if (have_left_q) begin
                right_hold_d = shift_d;
                pub_d        = 1'b1;
                have_left_d  = 1'b0;
              end
            end
`ifdef I2S_FRAME_CHECK_EN
            if (lr_edge) begin
              slot_cnt_d = CW'(1);
              if (slot_cnt_q != CW'(SLOT_W)) begin
                frame_err_d = 1'b1;
                state_d     = SYNC;
                have_left_d = 1'b0;
                pub_d       = 1'b0;
              end
            end else if (slot_cnt_q <= CW'(SLOT_W)) begin
              slot_cnt_d = slot_cnt_q + 1'b1;
            end
`endif
          end
        end
      endcase
    end

    if (pub_q) begin
      if (!out_valid_q || out_ready) begin
        out_left_d  = left_hold_q;
        out_right_d = right_hold_q;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_s1_q    <= 1'b0;
      bclk_s2_q    <= 1'b0;
      bclk_s3_q    <= 1'b0;
      lr_s1_q      <= 1'b0;
      lr_s2_q      <= 1'b0;
      sd_s1_q      <= 1'b0;
      sd_s2_q      <= 1'b0;
      state_q      <= SYNC;
      chan_q       <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      have_left_q  <= 1'b0;
      pub_q        <= 1'b0;
      lr_prev_q    <= 1'b0;
      out_left_q   <= '0;
      out_right_q  <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef I2S_FRAME_CHECK_EN
      slot_cnt_q   <= '0;
      frame_err_q  <= 1'b0;
`endif
    end else begin
      bclk_s1_q    <= i2s_bclk;
      bclk_s2_q    <= bclk_s1_q;
      bclk_s3_q    <= bclk_s2_q;
      lr_s1_q      <= i2s_lrclk;
      lr_s2_q      <= lr_s1_q;
      sd_s1_q      <= i2s_sdata;
      sd_s2_q      <= sd_s1_q;
      state_q      <= state_d;
      chan_q       <= chan_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      have_left_q  <= have_left_d;
      pub_q        <= pub_d;
      lr_prev_q    <= lr_prev_d;
      out_left_q   <= out_left_d;
      out_right_q  <= out_right_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
`ifdef I2S_FRAME_CHECK_EN
      slot_cnt_q   <= slot_cnt_d;
      frame_err_q  <= frame_err_d;
`endif
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
`ifdef I2S_FRAME_CHECK_EN
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif
endmodule
